// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory controller.
// The arbiter connects through the slave modport; its environment uses master.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [1:0]            cpu_op;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_done;
   logic                  cpu_err;
   logic [1:0]            dbg_op;
   logic [ADDR_WIDTH-1:0] dbg_addr;
   logic [DATA_WIDTH-1:0] dbg_wdata;
   logic                  dbg_done;
   logic                  dbg_err;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            mem_op;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_done;
   logic                  grant_cpu;
   logic                  grant_dbg;

   modport slave (
      input  cpu_op, cpu_addr, cpu_wdata, dbg_op, dbg_addr, dbg_wdata, mem_rdata, mem_done,
      output cpu_done, cpu_err, dbg_done, dbg_err, rdata, mem_op, mem_addr, mem_wdata,
             grant_cpu, grant_dbg
   );

   modport master (
      output cpu_op, cpu_addr, cpu_wdata, dbg_op, dbg_addr, dbg_wdata, mem_rdata, mem_done,
      input  cpu_done, cpu_err, dbg_done, dbg_err, rdata, mem_op, mem_addr, mem_wdata,
             grant_cpu, grant_dbg
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between the CPU and the
// debug/loader port, with a grant locked per transaction and a watchdog abort.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 64
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] MEM_NOP   = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;
   localparam int WDOG_W = $clog2(TIMEOUT + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT_CPU = 2'd1, GNT_DBG = 2'd2} state_t;

   state_t                state, state_nxt;
   logic                  last, last_nxt;     // last served: 0=CPU, 1=DBG
   logic [WDOG_W-1:0]     wdog, wdog_nxt;
   logic                  cpu_req, dbg_req, own_req, expire;
   logic [1:0]            own_op;
   logic [ADDR_WIDTH-1:0] own_addr;
   logic [DATA_WIDTH-1:0] own_wdata;

   assign cpu_req = (bus.cpu_op == MEM_READ) || (bus.cpu_op == MEM_WRITE);
   assign dbg_req = (bus.dbg_op == MEM_READ) || (bus.dbg_op == MEM_WRITE);

   // Owner's request is passed straight through, never latched at grant time.
   assign own_op    = (state == GNT_DBG) ? bus.dbg_op    : bus.cpu_op;
   assign own_addr  = (state == GNT_DBG) ? bus.dbg_addr  : bus.cpu_addr;
   assign own_wdata = (state == GNT_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
   assign own_req   = ((state == GNT_CPU) && cpu_req) || ((state == GNT_DBG) && dbg_req);
   assign expire    = own_req && !bus.mem_done && (wdog == WDOG_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         last  <= 1'b1;
         wdog  <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         wdog  <= wdog_nxt;
      end
   end

   // NOTE: every combinational output is given a default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      wdog_nxt  = wdog;
      unique case (state)
         IDLE: begin
            if (cpu_req && dbg_req) state_nxt = last ? GNT_CPU : GNT_DBG;
            else if (cpu_req)       state_nxt = GNT_CPU;
            else if (dbg_req)       state_nxt = GNT_DBG;
         end
         GNT_CPU, GNT_DBG: begin
            // Completion, requester abandon and watchdog abort all close the grant.
            if (bus.mem_done || !own_req || expire) begin
               state_nxt = IDLE;
               last_nxt  = (state == GNT_DBG);
               wdog_nxt  = '0;
            end else begin
               wdog_nxt = wdog + WDOG_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_op    = MEM_NOP;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.cpu_done  = 1'b0;
      bus.cpu_err   = 1'b0;
      bus.dbg_done  = 1'b0;
      bus.dbg_err   = 1'b0;
      if (state == GNT_CPU || state == GNT_DBG) begin
         bus.mem_op    = (own_req && !expire) ? own_op : MEM_NOP;
         bus.mem_addr  = own_addr;
         bus.mem_wdata = own_wdata;
         if (state == GNT_CPU) begin
            bus.cpu_done = bus.mem_done || expire;
            bus.cpu_err  = expire;
         end else begin
            bus.dbg_done = bus.mem_done || expire;
            bus.dbg_err  = expire;
         end
      end
   end

   assign bus.grant_cpu = (state == GNT_CPU);
   assign bus.grant_dbg = (state == GNT_DBG);
   assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level owner/round-robin model.
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 64;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: who owns the port (0 none, 1 cpu, 2 dbg), who was served last,
   // and how long the current owner has been waiting.
   int m_owner, m_last, m_wait;
   logic       e_gc, e_gd, e_cd, e_ce, e_dd, e_de, e_req, e_to;
   logic [1:0] e_op;
   logic [7:0] e_addr, e_wdata;

   logic       s_gc, s_gd, s_cd, s_ce, s_dd, s_de;
   logic [1:0] s_op;
   logic [7:0] s_addr, s_wdata, s_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic is_req(input logic [1:0] op);
      return (op == 2'b01) || (op == 2'b10);
   endfunction

   task automatic predict();
      logic [1:0] op;
      e_gc = (m_owner == 1); e_gd = (m_owner == 2);
      e_cd = 0; e_ce = 0; e_dd = 0; e_de = 0;
      e_op = 2'b00; e_addr = 8'h00; e_wdata = 8'h00; e_req = 0; e_to = 0;
      if (m_owner != 0) begin
         op      = (m_owner == 1) ? bus.cpu_op    : bus.dbg_op;
         e_addr  = (m_owner == 1) ? bus.cpu_addr  : bus.dbg_addr;
         e_wdata = (m_owner == 1) ? bus.cpu_wdata : bus.dbg_wdata;
         e_req   = is_req(op);
         e_to    = e_req && !bus.mem_done && (m_wait == TO - 1);
         e_op    = (e_req && !e_to) ? op : 2'b00;
         if (m_owner == 1) begin e_cd = bus.mem_done || e_to; e_ce = e_to; end
         else              begin e_dd = bus.mem_done || e_to; e_de = e_to; end
      end
   endtask

   task automatic update();
      logic cr, dr;
      cr = is_req(bus.cpu_op);
      dr = is_req(bus.dbg_op);
      predict();
      if (!reset) begin
         m_owner = 0; m_last = 2; m_wait = 0;
      end else if (m_owner == 0) begin
         if (cr && dr)  m_owner = (m_last == 1) ? 2 : 1;
         else if (cr)   m_owner = 1;
         else if (dr)   m_owner = 2;
      end else if (bus.mem_done || !e_req || e_to) begin
         m_last = m_owner; m_owner = 0; m_wait = 0;
      end else begin
         m_wait++;
      end
   endtask

   // One clock cycle: compare mid-cycle, then advance the model at the edge.
   task automatic step();
      @(negedge clock);
      predict();
      check("grant_cpu", bus.grant_cpu, e_gc);
      check("grant_dbg", bus.grant_dbg, e_gd);
      check("mem_op",    bus.mem_op,    e_op);
      check("mem_addr",  bus.mem_addr,  e_addr);
      check("mem_wdata", bus.mem_wdata, e_wdata);
      check("cpu_done",  bus.cpu_done,  e_cd);
      check("cpu_err",   bus.cpu_err,   e_ce);
      check("dbg_done",  bus.dbg_done,  e_dd);
      check("dbg_err",   bus.dbg_err,   e_de);
      check("rdata",     bus.rdata,     bus.mem_rdata);
      s_gc = bus.grant_cpu; s_gd = bus.grant_dbg; s_cd = bus.cpu_done; s_ce = bus.cpu_err;
      s_dd = bus.dbg_done;  s_de = bus.dbg_err;   s_op = bus.mem_op;   s_addr = bus.mem_addr;
      s_wdata = bus.mem_wdata; s_rdata = bus.rdata;
      @(posedge clock);
      update();
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_op = 2'b00; bus.dbg_op = 2'b00; bus.mem_done = 1'b0;
   endtask

   int rr_exp[8] = '{0, 1, 0, 2, 0, 1, 0, 2};

   initial begin
      reset = 1'b0;
      bus.cpu_op = 2'b01; bus.cpu_addr = 8'h33; bus.cpu_wdata = 8'h00;
      bus.dbg_op = 2'b01; bus.dbg_addr = 8'h44; bus.dbg_wdata = 8'h00;
      bus.mem_rdata = 8'h00; bus.mem_done = 1'b0;
      m_owner = 0; m_last = 2; m_wait = 0;
      @(posedge clock);
      #1;

      // Reset held with both requesting, then CPU wins the first tie.
      repeat (3) step();
      check("rst_mem_op", s_op, 2'b00);
      check("rst_grants", {s_gc, s_gd}, 2'b00);
      reset = 1'b1;
      step();
      step();
      check("first_grant_cpu", s_gc, 1'b1);
      check("first_mem_op", s_op, 2'b01);
      check("first_mem_addr", s_addr, 8'h33);
      bus.mem_done = 1'b1;
      step();
      idle_inputs();
      step();

      // Single CPU read completing in the third granted cycle.
      bus.cpu_op = 2'b01; bus.cpu_addr = 8'h12;
      step();
      step();
      step();
      bus.mem_done = 1'b1; bus.mem_rdata = 8'hA5;
      step();
      check("rd_cpu_done", s_cd, 1'b1);
      check("rd_rdata", s_rdata, 8'hA5);
      check("rd_dbg_done", s_dd, 1'b0);
      idle_inputs();
      step();
      check("rd_turnaround_op", s_op, 2'b00);

      // Debug write.
      bus.dbg_op = 2'b10; bus.dbg_addr = 8'h40; bus.dbg_wdata = 8'h3C;
      step();
      repeat (2) begin
         step();
         check("wr_mem_op", s_op, 2'b10);
         check("wr_mem_addr", s_addr, 8'h40);
         check("wr_mem_wdata", s_wdata, 8'h3C);
      end
      bus.mem_done = 1'b1;
      step();
      check("wr_dbg_done", s_dd, 1'b1);
      check("wr_dbg_err", s_de, 1'b0);
      idle_inputs();
      step();

      // Round-robin contention, memory completes in the first granted cycle.
      bus.cpu_op = 2'b10; bus.dbg_op = 2'b10;
      for (int i = 0; i < 8; i++) begin
         bus.mem_done = bus.grant_cpu | bus.grant_dbg;
         step();
         check("rr_order", s_gc ? 1 : (s_gd ? 2 : 0), rr_exp[i]);
      end
      idle_inputs();
      step();

      // Watchdog abort on a CPU read with a debug request pending.
      bus.cpu_op = 2'b01; bus.cpu_addr = 8'h55;
      bus.dbg_op = 2'b01; bus.dbg_addr = 8'h66;
      step();
      for (int k = 1; k <= TO; k++) begin
         step();
         if (k == TO - 1) check("to_early_err", s_ce, 1'b0);
         if (k == TO) begin
            check("to_cpu_done", s_cd, 1'b1);
            check("to_cpu_err", s_ce, 1'b1);
            check("to_mem_op", s_op, 2'b00);
         end
      end
      step();
      check("to_idle_op", s_op, 2'b00);
      check("to_idle_gc", s_gc, 1'b0);
      step();
      check("to_dbg_next", s_gd, 1'b1);
      check("to_dbg_addr", s_addr, 8'h66);
      bus.mem_done = 1'b1;
      step();
      idle_inputs();
      step();

      // CPU abandons its request mid-grant.
      bus.cpu_op = 2'b01; bus.cpu_addr = 8'h21;
      step();
      step();
      check("ab_granted", s_gc, 1'b1);
      bus.cpu_op = 2'b00;
      step();
      check("ab_no_done", s_cd, 1'b0);
      check("ab_mem_op", s_op, 2'b00);
      step();
      check("ab_idle", s_gc, 1'b0);

      // Reset while debug owns the port.
      bus.dbg_op = 2'b10; bus.dbg_addr = 8'h70; bus.dbg_wdata = 8'h01;
      step();
      step();
      check("mr_granted", s_gd, 1'b1);
      reset = 1'b0;
      step();
      reset = 1'b1; bus.cpu_op = 2'b01; bus.dbg_op = 2'b01;
      step();
      check("mr_gd_clear", s_gd, 1'b0);
      check("mr_mem_op", s_op, 2'b00);
      step();
      check("mr_cpu_wins", s_gc, 1'b1);

      // Random traffic with periodic memory stalls long enough to trip the watchdog.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 4) == 0) bus.cpu_op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) bus.dbg_op = 2'($urandom_range(0, 3));
         bus.cpu_addr  = 8'($urandom); bus.cpu_wdata = 8'($urandom);
         bus.dbg_addr  = 8'($urandom); bus.dbg_wdata = 8'($urandom);
         bus.mem_rdata = 8'($urandom);
         bus.mem_done  = ((i % 500) >= 80) && ($urandom_range(0, 3) == 0);
         reset         = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
